// File: rtl/reg_file_2r1w.sv
// Two-read, one-write register file with per-bit write mask, write-first read bypass,
// a sticky out-of-range error flag and a one-entry-per-cycle clear sweep.
module reg_file_2r1w #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wen,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] wmask,
    input  logic             oen_a,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] dout_a,
    input  logic             oen_b,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] dout_b,
    input  logic             clr,
    output logic             busy,
    output logic             err
);

    localparam int unsigned AW1      = AW + 1;
    localparam logic [AW:0]   DEPTH_W = AW1'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    typedef enum logic [0:0] {IDLE, CLEAR} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     ptr_q, ptr_d;
    logic [WIDTH-1:0]  regs_q [DEPTH];
    logic [WIDTH-1:0]  regs_d [DEPTH];
    logic [WIDTH-1:0]  dout_a_q, dout_a_d;
    logic [WIDTH-1:0]  dout_b_q, dout_b_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic              waddr_ok, ra_ok, rb_ok;
    logic              wr_ok;
    logic [WIDTH-1:0]  wr_cur, merged;
    logic [WIDTH-1:0]  rd_a, rd_b;

    assign waddr_ok = {1'b0, waddr}   < DEPTH_W;
    assign ra_ok    = {1'b0, raddr_a} < DEPTH_W;
    assign rb_ok    = {1'b0, raddr_b} < DEPTH_W;

    // A write lands only in IDLE without a competing clear request.
    assign wr_ok  = wen && waddr_ok && !clr && (state_q == IDLE);
    assign wr_cur = waddr_ok ? regs_q[waddr] : '0;
    assign merged = (din & wmask) | (wr_cur & ~wmask);

    // Write-first: a same-edge write to the read address is forwarded.
    assign rd_a = !ra_ok ? '0 : (wr_ok && (waddr == raddr_a)) ? merged : regs_q[raddr_a];
    assign rd_b = !rb_ok ? '0 : (wr_ok && (waddr == raddr_b)) ? merged : regs_q[raddr_b];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            CLEAR: begin
                ptr_d = ptr_q + AW'(1);
                if (ptr_q == LAST) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        regs_d   = regs_q;
        dout_a_d = dout_a_q;
        dout_b_d = dout_b_q;
        busy_d   = busy_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (wr_ok) begin
                    regs_d[waddr] = merged;
                end
                if (oen_a) begin
                    dout_a_d = rd_a;
                end
                if (oen_b) begin
                    dout_b_d = rd_b;
                end
                if (clr) begin
                    busy_d = 1'b1;
                    err_d  = 1'b0;
                end else if ((wen && !waddr_ok) || (oen_a && !ra_ok) || (oen_b && !rb_ok)) begin
                    err_d = 1'b1;
                end
            end
            CLEAR: begin
                regs_d[ptr_q] = '0;
                if (oen_a) begin
                    dout_a_d = '0;
                end
                if (oen_b) begin
                    dout_b_d = '0;
                end
                busy_d = (ptr_q != LAST);
            end
            default: busy_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= '0;
            end
            dout_a_q <= '0;
            dout_b_q <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            dout_a_q <= dout_a_d;
            dout_b_q <= dout_b_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    assign dout_a = dout_a_q;
    assign dout_b = dout_b_q;
    assign busy   = busy_q;
    assign err    = err_q;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w (WIDTH=8, DEPTH=6): vector table plus clear/reset sequences.
module tb_reg_file_2r1w;

    logic       clk;
    logic       rst_n;
    logic       wen;
    logic [2:0] waddr;
    logic [7:0] din;
    logic [7:0] wmask;
    logic       oen_a;
    logic [2:0] raddr_a;
    logic [7:0] dout_a;
    logic       oen_b;
    logic [2:0] raddr_b;
    logic [7:0] dout_b;
    logic       clr;
    logic       busy;
    logic       err;

    int n_pass = 0;
    int n_total = 0;

    reg_file_2r1w #(.WIDTH(8), .DEPTH(6)) dut (
        .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .din(din), .wmask(wmask),
        .oen_a(oen_a), .raddr_a(raddr_a), .dout_a(dout_a),
        .oen_b(oen_b), .raddr_b(raddr_b), .dout_b(dout_b),
        .clr(clr), .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wen;
        logic [2:0] wa;
        logic [7:0] din;
        logic [7:0] wm;
        logic       oa;
        logic [2:0] ra;
        logic       ob;
        logic [2:0] rb;
        logic [7:0] ea;
        logic [7:0] eb;
        logic       er;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic w, input logic [2:0] wa, input logic [7:0] d,
                                input logic [7:0] wm, input logic oa, input logic [2:0] ra,
                                input logic ob, input logic [2:0] rb, input logic [7:0] ea,
                                input logic [7:0] eb, input logic er);
        vec_t v;
        v.wen = w;  v.wa = wa; v.din = d;  v.wm = wm;
        v.oa  = oa; v.ra = ra; v.ob  = ob; v.rb = rb;
        v.ea  = ea; v.eb = eb; v.er  = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [2:0] wa, input logic [7:0] d,
                         input logic [7:0] wm, input logic oa, input logic [2:0] ra,
                         input logic ob, input logic [2:0] rb, input logic c);
        wen = w; waddr = wa; din = d; wmask = wm;
        oen_a = oa; raddr_a = ra; oen_b = ob; raddr_b = rb; clr = c;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_v;
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("reset dout_a", dout_a, 0);
        chk("reset dout_b", dout_b, 0);
        chk("reset busy", busy, 0);
        chk("reset err", err, 0);
        #20 rst_n = 1'b1;
        step();

        // fill, crossed reads, masked write with bypass, hold, out-of-range
        for (int i = 0; i < 6; i++) begin
            tbl.push_back(mk(1, 3'(i), 8'((i + 1) * 8'h11), 8'hFF, 0, 0, 0, 0, 8'h00, 8'h00, 0));
        end
        for (int i = 0; i < 6; i++) begin
            tbl.push_back(mk(0, 0, 0, 0, 1, 3'(i), 1, 3'(5 - i),
                             8'((i + 1) * 8'h11), 8'((6 - i) * 8'h11), 0));
        end
        tbl.push_back(mk(1, 2, 8'hAA, 8'hFF, 0, 0, 0, 0, 8'h66, 8'h11, 0));
        tbl.push_back(mk(1, 2, 8'h55, 8'h0F, 1, 2, 1, 2, 8'hA5, 8'hA5, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 2, 1, 3, 8'hA5, 8'h44, 0));
        tbl.push_back(mk(1, 2, 8'hFF, 8'h00, 1, 2, 0, 0, 8'hA5, 8'h44, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 8'hA5, 8'h44, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4, 0, 1, 8'hA5, 8'h44, 0));
        tbl.push_back(mk(1, 7, 8'hFF, 8'hFF, 0, 0, 0, 0, 8'hA5, 8'h44, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 6, 0, 0, 8'h00, 8'h44, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 5, 8'h11, 8'h66, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 7, 8'h22, 8'h00, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 2, 1, 4, 8'hA5, 8'h55, 1));

        foreach (tbl[i]) begin
            drive(tbl[i].wen, tbl[i].wa, tbl[i].din, tbl[i].wm, tbl[i].oa, tbl[i].ra,
                  tbl[i].ob, tbl[i].rb, 0);
            step();
            chk($sformatf("v%0d dout_a", i), dout_a, tbl[i].ea);
            chk($sformatf("v%0d dout_b", i), dout_b, tbl[i].eb);
            chk($sformatf("v%0d err", i), err, tbl[i].er);
            chk($sformatf("v%0d busy", i), busy, 0);
        end

        // clear sweep with a competing write; busy for exactly 6 cycles
        drive(1, 0, 8'h99, 8'hFF, 0, 0, 0, 0, 1);
        step();
        chk("clr busy0", busy, 1);
        chk("clr err", err, 0);
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 8'h99, 8'hFF, 1, 3'(k), 1, 3'(5 - k), 1);
            step();
            chk($sformatf("sweep%0d busy", k), busy, 1);
            chk($sformatf("sweep%0d dout_a", k), dout_a, 0);
            chk($sformatf("sweep%0d dout_b", k), dout_b, 0);
            chk($sformatf("sweep%0d err", k), err, 0);
        end
        drive(0, 0, 0, 0, 1, 5, 0, 0, 0);
        step();
        chk("sweep end busy", busy, 0);
        chk("sweep end dout_a", dout_a, 0);
        drive(1, 3, 8'h77, 8'hFF, 1, 3, 1, 0, 0);
        step();
        chk("post-sweep write dout_a", dout_a, 8'h77);
        chk("post-sweep dout_b", dout_b, 0);
        for (int i = 0; i < 6; i++) begin
            exp_v = (i == 3) ? 8'h77 : 8'h00;
            drive(0, 0, 0, 0, 1, 3'(i), 1, 3'(i), 0);
            step();
            chk($sformatf("cleared a%0d", i), dout_a, exp_v);
            chk($sformatf("cleared b%0d", i), dout_b, exp_v);
        end

        // reset mid-sweep aborts it
        for (int i = 0; i < 6; i++) begin
            drive(1, 3'(i), 8'((i + 1) * 8'h11), 8'hFF, 0, 0, 0, 0, 0);
            step();
        end
        drive(0, 0, 0, 0, 1, 5, 1, 4, 0);
        step();
        chk("pre-reset dout_a", dout_a, 8'h66);
        chk("pre-reset dout_b", dout_b, 8'h55);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step();
        chk("mid-sweep busy", busy, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("async rst busy", busy, 0);
        chk("async rst dout_a", dout_a, 0);
        chk("async rst dout_b", dout_b, 0);
        chk("async rst err", err, 0);
        step();
        chk("in-reset busy", busy, 0);
        #3 rst_n = 1'b1;
        drive(1, 4, 8'h5A, 8'hFF, 1, 5, 1, 4, 0);
        step();
        chk("after rst busy", busy, 0);
        chk("after rst dout_a", dout_a, 0);
        chk("after rst bypass b", dout_b, 8'h5A);
        for (int i = 0; i < 6; i++) begin
            exp_v = (i == 4) ? 8'h5A : 8'h00;
            drive(0, 0, 0, 0, 1, 3'(i), 0, 0, 0);
            step();
            chk($sformatf("after rst a%0d", i), dout_a, exp_v);
            chk($sformatf("after rst busy%0d", i), busy, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
